// File: rtl/beam_rbg_sequencer.sv
// Per-symbol RE framing for the beam power calculator: counts the RE-valid stream,
// cuts it into RBGs and drives the calculator's sop/eop/rbg_load/index/symbol controls.
module beam_rbg_sequencer #(
    parameter int unsigned RE_PER_RB = 12,
    parameter int unsigned MAX_PRB   = 273,
    parameter int unsigned NSYMB     = 14
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [1:0]       i_rbg_size,
    input  logic [8:0]       i_prb_num,
    input  logic [NSYMB-1:0] i_calc_mask,
    input  logic [3:0]       i_symb_idx,
    input  logic             i_symb_start,
    input  logic             i_re_vld,
    output logic             o_vld,
    output logic             o_sop,
    output logic             o_eop,
    output logic             o_rbg_load,
    output logic [7:0]       o_re_num,
    output logic [7:0]       o_rbg_num,
    output logic             o_symb_clr,
    output logic             o_symb_1st,
    output logic             o_err
);

    localparam int unsigned RE_W  = 8;
    localparam int unsigned SYM_W = $clog2(RE_PER_RB * MAX_PRB + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Reset: asserts asynchronously, releases two clocks after i_reset_n rises
    logic rst_meta_q;
    logic rst_sync_n_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_meta_q   <= 1'b0;
            rst_sync_n_q <= 1'b0;
        end else begin
            rst_meta_q   <= 1'b1;
            rst_sync_n_q <= rst_meta_q;
        end
    end

    state_e            state_q, state_d;
    logic [RE_W-1:0]   re_cnt_q, re_cnt_d;
    logic [RE_W-1:0]   rbg_cnt_q, rbg_cnt_d;
    logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic [RE_W-1:0]   rbg_re_q, rbg_re_d;
    logic [SYM_W-1:0]  tot_re_q, tot_re_d;
    logic              vld_q, vld_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              rbg_load_q, rbg_load_d;
    logic [RE_W-1:0]   re_num_q, re_num_d;
    logic [RE_W-1:0]   rbg_num_q, rbg_num_d;
    logic              symb_clr_q, symb_clr_d;
    logic              symb_1st_q, symb_1st_d;
    logic              err_q, err_d;

    // Start-time configuration decode
    logic [RE_W-1:0]   rbg_rb_c;
    logic [8:0]        prb_clamp_c;
    logic [RE_W-1:0]   rbg_re_start_c;
    logic [SYM_W-1:0]  tot_re_start_c;
    logic              start_ok_c;

    assign rbg_rb_c       = (i_rbg_size == 2'b00) ? RE_W'(4)
                          : (i_rbg_size == 2'b01) ? RE_W'(8) : RE_W'(16);
    assign prb_clamp_c    = (i_prb_num > 9'(MAX_PRB)) ? 9'(MAX_PRB) : i_prb_num;
    assign rbg_re_start_c = RE_W'(RE_PER_RB) * rbg_rb_c;
    assign tot_re_start_c = SYM_W'(RE_PER_RB) * SYM_W'(prb_clamp_c);
    assign start_ok_c     = (i_prb_num != 9'd0) && (32'(i_symb_idx) < NSYMB);

    always_comb begin
        state_d    = state_q;
        re_cnt_d   = re_cnt_q;
        rbg_cnt_d  = rbg_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        rbg_re_d   = rbg_re_q;
        tot_re_d   = tot_re_q;
        vld_d      = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        rbg_load_d = 1'b0;
        re_num_d   = re_num_q;
        rbg_num_d  = rbg_num_q;
        symb_clr_d = 1'b0;
        symb_1st_d = symb_1st_q;
        err_d      = 1'b0;

        if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end

        if (i_symb_start) begin
            // A start while running aborts the old symbol without an eop
            if (state_q == ST_RUN) begin
                err_d = 1'b1;
            end
            if (start_ok_c) begin
                state_d    = ST_RUN;
                re_cnt_d   = '0;
                rbg_cnt_d  = '0;
                sym_cnt_d  = '0;
                rbg_re_d   = rbg_re_start_c;
                tot_re_d   = tot_re_start_c;
                symb_clr_d = (i_symb_idx == 4'd0);
                symb_1st_d = i_calc_mask[i_symb_idx];
            end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
        end else if (i_re_vld) begin
            if (state_q == ST_RUN) begin
                vld_d      = 1'b1;
                sop_d      = (sym_cnt_q == '0);
                eop_d      = (sym_cnt_q == tot_re_q - SYM_W'(1));
                rbg_load_d = (re_cnt_q == '0);
                re_num_d   = re_cnt_q;
                rbg_num_d  = rbg_cnt_q;
                if (sym_cnt_q == tot_re_q - SYM_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    sym_cnt_d = sym_cnt_q + SYM_W'(1);
                    if (re_cnt_q == rbg_re_q - RE_W'(1)) begin
                        re_cnt_d  = '0;
                        rbg_cnt_d = rbg_cnt_q + RE_W'(1);
                    end else begin
                        re_cnt_d = re_cnt_q + RE_W'(1);
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge rst_sync_n_q) begin
        if (!rst_sync_n_q) begin
            state_q    <= ST_IDLE;
            re_cnt_q   <= '0;
            rbg_cnt_q  <= '0;
            sym_cnt_q  <= '0;
            rbg_re_q   <= '0;
            tot_re_q   <= '0;
            vld_q      <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            rbg_load_q <= 1'b0;
            re_num_q   <= '0;
            rbg_num_q  <= '0;
            symb_clr_q <= 1'b0;
            symb_1st_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            re_cnt_q   <= re_cnt_d;
            rbg_cnt_q  <= rbg_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            rbg_re_q   <= rbg_re_d;
            tot_re_q   <= tot_re_d;
            vld_q      <= vld_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            rbg_load_q <= rbg_load_d;
            re_num_q   <= re_num_d;
            rbg_num_q  <= rbg_num_d;
            symb_clr_q <= symb_clr_d;
            symb_1st_q <= symb_1st_d;
            err_q      <= err_d;
        end
    end

    assign o_vld      = vld_q;
    assign o_sop      = sop_q;
    assign o_eop      = eop_q;
    assign o_rbg_load = rbg_load_q;
    assign o_re_num   = re_num_q;
    assign o_rbg_num  = rbg_num_q;
    assign o_symb_clr = symb_clr_q;
    assign o_symb_1st = symb_1st_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_beam_rbg_sequencer.sv
// Bench for beam_rbg_sequencer: symbol-level reference model (RE index div/mod arithmetic)
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_beam_rbg_sequencer;

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic [1:0]  i_rbg_size = 2'b00;
    logic [8:0]  i_prb_num = 9'd0;
    logic [13:0] i_calc_mask = 14'd0;
    logic [3:0]  i_symb_idx = 4'd0;
    logic        i_symb_start = 1'b0;
    logic        i_re_vld = 1'b0;
    logic        o_vld, o_sop, o_eop, o_rbg_load, o_symb_clr, o_symb_1st, o_err;
    logic [7:0]  o_re_num, o_rbg_num;

    beam_rbg_sequencer dut (
        .i_clk        (clk),
        .i_reset_n    (i_reset_n),
        .i_rbg_size   (i_rbg_size),
        .i_prb_num    (i_prb_num),
        .i_calc_mask  (i_calc_mask),
        .i_symb_idx   (i_symb_idx),
        .i_symb_start (i_symb_start),
        .i_re_vld     (i_re_vld),
        .o_vld        (o_vld),
        .o_sop        (o_sop),
        .o_eop        (o_eop),
        .o_rbg_load   (o_rbg_load),
        .o_re_num     (o_re_num),
        .o_rbg_num    (o_rbg_num),
        .o_symb_clr   (o_symb_clr),
        .o_symb_1st   (o_symb_1st),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    // Reference model: symbol state plus RE index n; RBG fields are n mod / div rbg size
    int m_mode = 0;        // 0 idle, 1 running a symbol, 2 just finished
    int m_n = 0;
    int m_rbg_re = 1;
    int m_tot = 1;
    int m_rst_cnt = 0;
    int e_vld = 0, e_sop = 0, e_eop = 0, e_load = 0, e_clr = 0, e_1st = 0, e_err = 0;
    int e_re_num = 0, e_rbg_num = 0;

    function automatic int rb_of(input logic [1:0] s);
        return (s == 2'b00) ? 4 : (s == 2'b01) ? 8 : 16;
    endfunction

    always @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_mode = 0; m_n = 0; m_rst_cnt = 0;
            e_vld = 0; e_sop = 0; e_eop = 0; e_load = 0; e_clr = 0; e_1st = 0; e_err = 0;
            e_re_num = 0; e_rbg_num = 0;
        end else if (m_rst_cnt < 2) begin
            m_rst_cnt = m_rst_cnt + 1;
        end else begin : model_step
            int m0;
            int prb;
            m0 = m_mode;
            e_vld = 0; e_sop = 0; e_eop = 0; e_load = 0; e_clr = 0; e_err = 0;
            if (m_mode == 2) m_mode = 0;
            if (i_symb_start) begin
                if (m0 == 1) e_err = 1;
                if (i_prb_num != 0 && int'(i_symb_idx) < 14) begin
                    prb      = (int'(i_prb_num) > 273) ? 273 : int'(i_prb_num);
                    m_mode   = 1;
                    m_n      = 0;
                    m_rbg_re = 12 * rb_of(i_rbg_size);
                    m_tot    = 12 * prb;
                    e_clr    = (i_symb_idx == 4'd0) ? 1 : 0;
                    e_1st    = int'(i_calc_mask[i_symb_idx]);
                end else begin
                    e_err  = 1;
                    m_mode = 0;
                end
            end else if (i_re_vld) begin
                if (m0 == 1) begin
                    e_vld     = 1;
                    e_sop     = (m_n == 0) ? 1 : 0;
                    e_eop     = (m_n == m_tot - 1) ? 1 : 0;
                    e_load    = (m_n % m_rbg_re == 0) ? 1 : 0;
                    e_re_num  = m_n % m_rbg_re;
                    e_rbg_num = m_n / m_rbg_re;
                    if (e_eop == 1) m_mode = 2;
                    m_n = m_n + 1;
                end else begin
                    e_err = 1;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int mon_vld = 0, mon_load = 0, mon_eop = 0, mon_err = 0, mon_clr = 0;
    int last_eop_re = -1, last_eop_rbg = -1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("vld",      int'(o_vld),      e_vld);
        chk("sop",      int'(o_sop),      e_sop);
        chk("eop",      int'(o_eop),      e_eop);
        chk("rbg_load", int'(o_rbg_load), e_load);
        chk("re_num",   int'(o_re_num),   e_re_num);
        chk("rbg_num",  int'(o_rbg_num),  e_rbg_num);
        chk("symb_clr", int'(o_symb_clr), e_clr);
        chk("symb_1st", int'(o_symb_1st), e_1st);
        chk("err",      int'(o_err),      e_err);
        if (o_vld) mon_vld = mon_vld + 1;
        if (o_vld && o_rbg_load) mon_load = mon_load + 1;
        if (o_err) mon_err = mon_err + 1;
        if (o_symb_clr) mon_clr = mon_clr + 1;
        if (o_vld && o_eop) begin
            mon_eop      = mon_eop + 1;
            last_eop_re  = int'(o_re_num);
            last_eop_rbg = int'(o_rbg_num);
        end
    endtask

    // One clock: drive inputs, wait for the next falling edge, check outputs
    task automatic step(input logic s, input logic v);
        i_symb_start = s;
        i_re_vld     = v;
        @(negedge clk);
        compare_all();
    endtask

    task automatic cfg(input logic [1:0] sz, input logic [8:0] prb, input logic [3:0] idx,
                       input logic [13:0] mask);
        i_rbg_size  = sz;
        i_prb_num   = prb;
        i_symb_idx  = idx;
        i_calc_mask = mask;
    endtask

    task automatic send_res(input int cnt);
        for (int k = 0; k < cnt; k++) step(1'b0, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int b_vld, b_load, b_eop, b_err, b_clr;

    task automatic snap();
        b_vld = mon_vld; b_load = mon_load; b_eop = mon_eop; b_err = mon_err; b_clr = mon_clr;
    endtask

    initial begin
        #1 i_reset_n = 1'b0;
        @(negedge clk);
        compare_all();
        chk("reset_vld", int'(o_vld), 0);
        chk("reset_re_num", int'(o_re_num), 0);
        step(1'b0, 1'b0);
        #2 i_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);

        // 1: 16-RB RBGs, 32 PRB, symbol 0, back-to-back
        cfg(2'b10, 9'd32, 4'd0, 14'h0001);
        snap();
        step(1'b1, 1'b0);
        chk("t1_symb_clr", int'(o_symb_clr), 1);
        send_res(384);
        chk("t1_eop_re_num", last_eop_re, 191);
        chk("t1_eop_rbg_num", last_eop_rbg, 1);
        chk("t1_vld_count", mon_vld - b_vld, 384);
        chk("t1_load_count", mon_load - b_load, 2);
        chk("t1_eop_count", mon_eop - b_eop, 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("t1_idle_err", int'(o_err), 1);
        step(1'b0, 1'b0);

        // 2: 4-RB RBGs, 10 PRB, idle every third cycle, config wiggled mid-symbol
        cfg(2'b00, 9'd10, 4'd1, 14'h0000);
        snap();
        step(1'b1, 1'b0);
        chk("t2_no_clr", int'(o_symb_clr), 0);
        begin
            int sent = 0;
            int c = 0;
            while (sent < 120) begin
                if (c == 10) cfg(2'b10, 9'd5, 4'd0, 14'h3fff);
                if (c % 3 == 2) begin
                    step(1'b0, 1'b0);
                    chk("t2_gap_vld", int'(o_vld), 0);
                end else begin
                    step(1'b0, 1'b1);
                    sent = sent + 1;
                end
                c = c + 1;
            end
        end
        chk("t2_eop_re_num", last_eop_re, 23);
        chk("t2_eop_rbg_num", last_eop_rbg, 2);
        chk("t2_load_count", mon_load - b_load, 3);
        chk("t2_vld_count", mon_vld - b_vld, 120);
        step(1'b0, 1'b0);

        // 3: PRB count clamped to 273, 8-RB RBGs
        cfg(2'b01, 9'd300, 4'd2, 14'h0004);
        snap();
        step(1'b1, 1'b0);
        send_res(3276);
        chk("t3_eop_re_num", last_eop_re, 11);
        chk("t3_eop_rbg_num", last_eop_rbg, 34);
        chk("t3_eop_count", mon_eop - b_eop, 1);
        step(1'b0, 1'b0);

        // 4: restart at RE 50 of a running symbol
        cfg(2'b10, 9'd32, 4'd3, 14'h0000);
        snap();
        step(1'b1, 1'b0);
        send_res(50);
        step(1'b1, 1'b0);
        chk("t4_abort_err", int'(o_err), 1);
        step(1'b0, 1'b1);
        chk("t4_sop", int'(o_sop), 1);
        chk("t4_re_num", int'(o_re_num), 0);
        chk("t4_rbg_num", int'(o_rbg_num), 0);
        send_res(383);
        chk("t4_eop_count", mon_eop - b_eop, 1);
        chk("t4_err_count", mon_err - b_err, 1);
        chk("t4_eop_re_num", last_eop_re, 191);
        step(1'b0, 1'b0);

        // 5: calc mask over symbols 0..3, single-PRB symbols, then invalid starts
        snap();
        for (int s = 0; s < 4; s++) begin
            cfg(2'b00, 9'd1, 4'(s), 14'h0003);
            step(1'b1, 1'b0);
            chk("t5_symb_1st", int'(o_symb_1st), (s < 2) ? 1 : 0);
            chk("t5_symb_clr", int'(o_symb_clr), (s == 0) ? 1 : 0);
            step(1'b0, 1'b1);
            chk("t5_sop_load", int'(o_sop & o_rbg_load), 1);
            send_res(11);
            chk("t5_eop", int'(o_eop), 1);
            chk("t5_eop_re_num", int'(o_re_num), 11);
            step(1'b0, 1'b0);
        end
        chk("t5_clr_count", mon_clr - b_clr, 1);
        cfg(2'b00, 9'd0, 4'd0, 14'h0003);
        step(1'b1, 1'b0);
        chk("t5_prb0_err", int'(o_err), 1);
        chk("t5_prb0_no_clr", int'(o_symb_clr), 0);
        step(1'b0, 1'b1);
        chk("t5_prb0_no_run", int'(o_vld), 0);
        chk("t5_prb0_re_err", int'(o_err), 1);
        cfg(2'b00, 9'd4, 4'd14, 14'h0003);
        step(1'b1, 1'b0);
        chk("t5_idx14_err", int'(o_err), 1);
        step(1'b0, 1'b0);

        // 6: reset asserted mid-RBG, stray RE after release, clean restart
        cfg(2'b00, 9'd10, 4'd5, 14'h0020);
        step(1'b1, 1'b0);
        send_res(70);
        i_re_vld = 1'b1;
        #2 i_reset_n = 1'b0;
        #1;
        chk("t6_rst_vld", int'(o_vld), 0);
        chk("t6_rst_re_num", int'(o_re_num), 0);
        chk("t6_rst_rbg_num", int'(o_rbg_num), 0);
        chk("t6_rst_symb_1st", int'(o_symb_1st), 0);
        step(1'b0, 1'b0);
        #2 i_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("t6_stray_err", int'(o_err), 1);
        snap();
        step(1'b1, 1'b0);
        chk("t6_symb_1st", int'(o_symb_1st), 1);
        step(1'b0, 1'b1);
        chk("t6_sop", int'(o_sop), 1);
        send_res(119);
        chk("t6_eop_re_num", last_eop_re, 23);
        chk("t6_eop_rbg_num", last_eop_rbg, 2);
        chk("t6_eop_count", mon_eop - b_eop, 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
